invsqrt_nr: RTL and testbench

- Parametrised successor to the single-precision `invsqrt` core: computes y = 1/sqrt(x) for an IEEE-754 binary32 input.
- Internals: seed LUT, NR_ITERS Newton-Raphson iterations on a fixed-point mantissa, one shared FRAC_W x FRAC_W multiplier.
- Keeps the existing start/ready interface, so current test-vector benches drive it unchanged. Adds a busy flag, fixed data-independent latency and explicit IEEE special-case handling.

---
 rtl/invsqrt_nr.sv | 199 +++++++++++++++++++
 tb/tb_invsqrt_nr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/invsqrt_nr.sv
`timescale 1ns/1ps
// 1/sqrt(x) for binary32: seed LUT, then NR_ITERS Newton-Raphson steps sharing one FRAC_W x FRAC_W multiplier.
// Latency 2+3*NR_ITERS edges from accept to ready for every input; start is ignored while a computation runs.
module invsqrt_nr #(
    parameter int FRAC_W    = 28,
    parameter int NR_ITERS  = 3,
    parameter int SEED_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy
);

    localparam int LUT_N = 2 ** SEED_BITS;
    localparam int LUT_W = LUT_N * FRAC_W;

    // Entry i = floor(2^(FRAC_W-2) / sqrt(mid)) found by bit-serial search on y^2*mid <= 1.
    function automatic logic [LUT_W-1:0] gen_lut();
        logic [LUT_W-1:0]  v;
        logic [127:0]      num;
        logic [127:0]      lim;
        logic [127:0]      c_w;
        logic [FRAC_W-1:0] y;
        logic [FRAC_W-1:0] c;
        v = '0;
        for (int i = 0; i < LUT_N; i++) begin
            num = 128'((LUT_N + 2 * (i % (LUT_N / 2)) + 1) << (i / (LUT_N / 2)));
            lim = 128'(LUT_N) << (2 * (FRAC_W - 2));
            y   = '0;
            for (int b = FRAC_W - 1; b >= 0; b--) begin
                c   = y | (FRAC_W'(1) << b);
                c_w = 128'(c);
                if (c_w * c_w * num <= lim) y = c;
            end
            v[i*FRAC_W +: FRAC_W] = y;
        end
        return v;
    endfunction

    localparam logic [LUT_W-1:0]  SEED_LUT = gen_lut();
    localparam logic [FRAC_W-1:0] FX_ONE   = FRAC_W'(1) << (FRAC_W - 2);
    localparam logic [FRAC_W-1:0] FX_1P5   = FRAC_W'(3) << (FRAC_W - 3);

    localparam logic [1:0] C_NORM = 2'd0;
    localparam logic [1:0] C_INF  = 2'd1;
    localparam logic [1:0] C_NAN  = 2'd2;
    localparam logic [1:0] C_ZERO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_MUL_YY, S_MUL_XYY, S_MUL_UPD, S_PACK, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [31:0]         r_opnd, r_out;
    logic [FRAC_W-1:0]   r_m, r_y, r_t;
    logic [7:0]          r_k;
    logic [1:0]          r_cls;
    logic [2:0]          r_iter;

    logic                w_accept, w_iter_last;
    logic                w_sign, w_odd;
    logic [7:0]          w_exp;
    logic [22:0]         w_frac;
    logic [8:0]          w_e;
    logic [55:0]         w_m_ext;
    logic [SEED_BITS-1:0] w_idx;
    logic [FRAC_W-1:0]   w_m, w_y0;
    logic [1:0]          w_cls;
    logic [FRAC_W-1:0]   w_ma, w_mb, w_prod_q;
    logic [2*FRAC_W-1:0] w_prod;
    logic [63:0]         w_fr64;
    logic [22:0]         w_mant;
    logic                w_rnd;
    logic [23:0]         w_mant_r;
    logic [7:0]          w_eo;
    logic [31:0]         w_norm, w_result;
    logic                w_unused;

    assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_iter_last = (int'(r_iter) == NR_ITERS - 1);

    // Operand decode; k = floor(e/2) is simply the upper bits of the two's-complement e.
    assign {w_sign, w_exp, w_frac} = r_opnd;
    assign w_e     = {1'b0, w_exp} - 9'd127;
    assign w_odd   = w_e[0];
    assign w_m_ext = w_odd ? {1'b1, w_frac, 32'b0} : {2'b01, w_frac, 31'b0};
    assign w_m     = w_m_ext[55 -: FRAC_W];
    assign w_idx   = {w_odd, w_frac[22 -: SEED_BITS-1]};
    assign w_y0    = SEED_LUT[int'(w_idx)*FRAC_W +: FRAC_W];

    always_comb begin
        w_cls = C_NORM;
        if (w_exp == 8'd0)
            w_cls = C_INF;
        else if (w_exp == 8'hFF)
            w_cls = (w_frac != 23'd0 || w_sign) ? C_NAN : C_ZERO;
        else if (w_sign)
            w_cls = C_NAN;
    end

    always_comb begin
        w_ma = r_y;
        w_mb = r_y;
        case (r_state)
            S_MUL_XYY: begin
                w_ma = r_m;
                w_mb = r_t;
            end
            S_MUL_UPD: w_mb = FX_1P5 - (r_t >> 1);
            default: ;
        endcase
    end

    assign w_prod   = {{FRAC_W{1'b0}}, w_ma} * {{FRAC_W{1'b0}}, w_mb};
    assign w_prod_q = w_prod[2*FRAC_W-3 -: FRAC_W];

    // y in (0.5,1): after the implicit shift-left its fraction starts at bit FRAC_W-4.
    assign w_fr64   = {r_y[FRAC_W-4:0], {(67-FRAC_W){1'b0}}};
    assign w_mant   = w_fr64[63:41];
    assign w_rnd    = w_fr64[40] & ((|w_fr64[39:0]) | w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {23'b0, w_rnd};
    assign w_eo     = 8'd126 - r_k + {7'b0, w_mant_r[23]};

    always_comb begin
        if (r_y >= FX_ONE)
            w_norm = {1'b0, 8'd127 - r_k, 23'b0};
        else
            w_norm = {1'b0, w_eo, w_mant_r[22:0]};
        case (r_cls)
            C_INF:   w_result = 32'h7F800000;
            C_NAN:   w_result = 32'h7FC00000;
            C_ZERO:  w_result = 32'h00000000;
            default: w_result = w_norm;
        endcase
    end

    assign w_unused = ^{w_prod[2*FRAC_W-1 -: 2], w_prod[FRAC_W-3:0], w_m_ext[55-FRAC_W:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_SEED;
            S_SEED:         w_next = S_MUL_YY;
            S_MUL_YY:       w_next = S_MUL_XYY;
            S_MUL_XYY:      w_next = S_MUL_UPD;
            S_MUL_UPD:      w_next = w_iter_last ? S_PACK : S_MUL_YY;
            S_PACK:         w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opnd <= '0;
            r_out  <= '0;
            r_m    <= '0;
            r_y    <= '0;
            r_t    <= '0;
            r_k    <= '0;
            r_cls  <= C_NORM;
            r_iter <= '0;
        end else begin
            if (w_accept) begin
                r_opnd <= float_in;
                r_iter <= '0;
            end
            case (r_state)
                S_SEED: begin
                    r_m   <= w_m;
                    r_y   <= w_y0;
                    r_k   <= w_e[8:1];
                    r_cls <= w_cls;
                end
                S_MUL_YY, S_MUL_XYY: r_t <= w_prod_q;
                S_MUL_UPD: begin
                    r_y    <= w_prod_q;
                    r_iter <= r_iter + 3'd1;
                end
                S_PACK:  r_out <= w_result;
                default: ;
            endcase
        end
    end

    assign float_out = r_out;
    assign ready     = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_invsqrt_nr.sv
`timescale 1ns/1ps
// Bench for invsqrt_nr: directed IEEE cases, handshake/reset scenarios and random operands vs a real-valued model.
module tb_invsqrt_nr;

    localparam int LAT = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] float_in = 32'h0;
    logic [31:0] float_out;
    logic        ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    invsqrt_nr dut (
        .clk(clk), .rst(rst), .start(start), .float_in(float_in),
        .float_out(float_out), .ready(ready), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want, input int tol);
        longint d;
        n_checks++;
        d = longint'(got) - longint'(want);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d), tol %0d",
                     tag, got, got, want, want, tol);
        end
    endtask

    function automatic real bits2real(input logic [31:0] x);
        real v;
        int  e;
        v = 1.0 + real'(int'(x[22:0])) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return v;
    endfunction

    function automatic logic [31:0] real2bits(input real r_in);
        real r, scaled, rem;
        int  ex, fi;
        r  = r_in;
        ex = 0;
        while (r >= 2.0) begin r = r / 2.0; ex++; end
        while (r < 1.0)  begin r = r * 2.0; ex--; end
        scaled = (r - 1.0) * 8388608.0;
        fi     = $rtoi(scaled);
        rem    = scaled - real'(fi);
        if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
        if (fi == 8388608) begin fi = 0; ex++; end
        return {1'b0, 8'(ex + 127), 23'(fi)};
    endfunction

    function automatic void ref_isqrt(input logic [31:0] x, output logic [31:0] y, output int tol);
        tol = 0;
        if (x[30:23] == 8'd0)                             y = 32'h7F800000;
        else if (x[30:23] == 8'hFF && (x[22:0] != 0 || x[31])) y = 32'h7FC00000;
        else if (x[30:23] == 8'hFF)                       y = 32'h00000000;
        else if (x[31])                                   y = 32'h7FC00000;
        else begin
            y   = real2bits(1.0 / $sqrt(bits2real(x)));
            tol = 2;
        end
    endfunction

    task automatic wait_ready(output int lat, output int busy_lo);
        lat = 0;
        busy_lo = 0;
        while (!ready && lat < 100) begin
            if (!busy) busy_lo++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] x, output logic [31:0] res, output int lat, output int busy_lo);
        @(negedge clk);
        start = 1'b1;
        float_in = x;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(lat, busy_lo);
        res = float_out;
    endtask

    logic [31:0] dir_x [12] = '{32'h40800000, 32'h3F800000, 32'h3E800000, 32'h4C800000,
                                32'h00000000, 32'h00000001, 32'hBF800000, 32'h7F800000,
                                32'h7FC00001, 32'h80000000, 32'hFF800000, 32'h40000000};
    logic [31:0] dir_y [12] = '{32'h3F000000, 32'h3F800000, 32'h40000000, 32'h39000000,
                                32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h00000000,
                                32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h3F3504F3};
    int          dir_t [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, x, want;
        int          lat, blo, tol, max_ulp;
        longint      d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", float_out, 32'h0, 0);
        check("rst_ready", 32'(ready), 32'h0, 0);
        check("rst_busy", 32'(busy), 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(dir_x[i], res, lat, blo);
            check($sformatf("dir%0d_val", i), res, dir_y[i], dir_t[i]);
            check($sformatf("dir%0d_lat", i), 32'(lat), 32'(LAT), 0);
            check($sformatf("dir%0d_busy", i), 32'(blo), 32'h0, 0);
        end

        // A start pulse mid-computation must not replace the operand.
        @(negedge clk);
        start = 1'b1;
        float_in = 32'h40800000;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin
            if (lat == 4) begin
                start = 1'b1;
                float_in = 32'h3F800000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("ign_val", float_out, 32'h3F000000, 0);
        check("ign_lat", 32'(lat), 32'(LAT), 0);

        repeat (20) @(posedge clk);
        #1;
        check("hold_ready", 32'(ready), 32'h1, 0);
        check("hold_busy", 32'(busy), 32'h0, 0);
        check("hold_val", float_out, 32'h3F000000, 0);

        // start held high through DONE re-accepts on the next edge.
        @(negedge clk);
        start = 1'b1;
        float_in = 32'h3E800000;
        @(posedge clk); #1;
        check("b2b_acc_ready", 32'(ready), 32'h0, 0);
        check("b2b_acc_busy", 32'(busy), 32'h1, 0);
        wait_ready(lat, blo);
        check("b2b1_val", float_out, 32'h40000000, 0);
        check("b2b1_lat", 32'(lat), 32'(LAT), 0);
        @(posedge clk); #1;
        check("b2b_reacc_ready", 32'(ready), 32'h0, 0);
        check("b2b_reacc_busy", 32'(busy), 32'h1, 0);
        start = 1'b0;
        wait_ready(lat, blo);
        check("b2b2_val", float_out, 32'h40000000, 0);
        check("b2b2_lat", 32'(lat), 32'(LAT), 0);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        start = 1'b1;
        float_in = 32'h40000000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out", float_out, 32'h0, 0);
        check("arst_ready", 32'(ready), 32'h0, 0);
        check("arst_busy", 32'(busy), 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_idle", 32'(ready | busy), 32'h0, 0);
        do_op(32'h40800000, res, lat, blo);
        check("arst_after_val", res, 32'h3F000000, 0);
        check("arst_after_lat", 32'(lat), 32'(LAT), 0);

        max_ulp = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 8)
                x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            else
                x = $urandom;
            ref_isqrt(x, want, tol);
            do_op(x, res, lat, blo);
            check($sformatf("rand x=%08h", x), res, want, tol);
            check("rand_lat", 32'(lat), 32'(LAT), 0);
            if (tol != 0) begin
                d = longint'(res) - longint'(want);
                if (d < 0) d = -d;
                if (int'(d) > max_ulp) max_ulp = int'(d);
            end
        end
        $display("random normals: max ulp error = %0d", max_ulp);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
